avalon_st_uart_link_arbiter: RTL

//   Packet-level scheduler sharing one Avalon-ST UART bridge among NUM_REQ requesters.

---
 rtl/avalon_st_uart_link_arbiter_pkg.sv | 17 +
 rtl/avalon_st_uart_link_arbiter_if.sv | 63 ++++++
 rtl/avalon_st_uart_link_arbiter_rr_arbiter.sv | 29 ++
 rtl/avalon_st_uart_link_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/avalon_st_uart_link_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST UART link arbiter.
package avalon_st_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RSP  = 2'd2
  } link_state_t;

  localparam int DATA_W = 8;

  // The timer must be able to hold RESP_TIMEOUT itself so it can saturate without wrapping.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/avalon_st_uart_link_arbiter_if.sv
// Requester, response, bridge and status signals of the link arbiter, bundled as one interface.
interface avalon_st_uart_link_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  import avalon_st_uart_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_sop;
  logic [NUM_REQ-1:0]        req_eop;

  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_sop;
  logic                      rsp_eop;
  logic                      rsp_error;

  logic                      tx_valid;
  logic                      tx_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_sop;
  logic                      tx_eop;

  logic                      rx_valid;
  logic                      rx_ready;
  logic [DATA_W-1:0]         rx_data;
  logic                      rx_sop;
  logic                      rx_eop;
  logic                      rx_error;

  logic [NUM_REQ-1:0]        grant;
  logic                      timeout;
  logic                      drop;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_sop, req_eop,
    output req_ready,
    output rsp_valid, rsp_data, rsp_sop, rsp_eop, rsp_error,
    input  rsp_ready,
    output tx_valid, tx_data, tx_sop, tx_eop,
    input  tx_ready,
    input  rx_valid, rx_data, rx_sop, rx_eop, rx_error,
    output rx_ready,
    output grant, timeout, drop
  );

  // Environment side: requesters plus the bridge.
  modport master (
    output req_valid, req_data, req_sop, req_eop,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_sop, rsp_eop, rsp_error,
    output rsp_ready,
    input  tx_valid, tx_data, tx_sop, tx_eop,
    output tx_ready,
    output rx_valid, rx_data, rx_sop, rx_eop, rx_error,
    input  rx_ready,
    input  grant, timeout, drop
  );

endinterface

// File: rtl/avalon_st_uart_link_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly above the last owner, wrapping to 0.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick
);

  logic [N-1:0] above_last;
  logic [N-1:0] masked_req;
  logic [N-1:0] base;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      if (gi == 0) begin : g_lsb
        assign above_last[gi] = 1'b0;
      end else begin : g_upper
        assign above_last[gi] = |last[gi-1:0];
      end
    end
  endgenerate

  // Nothing above the last owner means the search wraps and the lowest index wins.
  assign masked_req = req & above_last;
  assign base       = (|masked_req) ? masked_req : req;
  assign pick       = base & (~base + N'(1));

endmodule

// File: rtl/avalon_st_uart_link_arbiter.sv
// Packet-level round-robin scheduler sharing one half-duplex Avalon-ST UART bridge among requesters.
module avalon_st_uart_link_arbiter
  import avalon_st_uart_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int WAIT_RESPONSE = 1,
  parameter int RESP_TIMEOUT  = 65535
) (
  input logic                           clk,
  input logic                           reset_n,
  avalon_st_uart_link_arbiter_if.slave  bus
);

  localparam int                    TIMER_W    = timer_width(RESP_TIMEOUT);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]    TIMER_MAX  = '1;
  localparam logic [NUM_REQ-1:0]    LAST_RESET = NUM_REQ'(1) << (NUM_REQ - 1);

  link_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   last_grant_q, last_grant_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic                 drop_q, drop_d;

  logic [NUM_REQ-1:0]   candidates;
  logic [NUM_REQ-1:0]   strays;
  logic [NUM_REQ-1:0]   pick;
  logic [DATA_W-1:0]    lane_data [NUM_REQ];

  logic                 sel_valid;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_sop;
  logic                 sel_eop;
  logic                 owner_rsp_ready;

  logic [NUM_REQ-1:0]   req_ready_c;
  logic [NUM_REQ-1:0]   rsp_valid_c;
  logic                 tx_valid_c;
  logic                 rx_ready_c;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = bus.req_data[DATA_W*gi +: DATA_W];
    end
  endgenerate

  assign candidates = bus.req_valid & bus.req_sop;
  assign strays     = bus.req_valid & ~bus.req_sop;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req  (candidates),
    .last (last_grant_q),
    .pick (pick)
  );

  // Granted-lane mux; grant_q is one-hot or zero, so at most one lane is selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = bus.req_valid[i];
        sel_data  = lane_data[i];
        sel_sop   = bus.req_sop[i];
        sel_eop   = bus.req_eop[i];
      end
    end
  end

  assign owner_rsp_ready = |(grant_q & bus.rsp_ready);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    timeout_d    = 1'b0;
    drop_d       = 1'b0;
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    tx_valid_c   = 1'b0;
    rx_ready_c   = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Non-sop beats outside a granted packet are swallowed so they cannot wedge a requester.
        req_ready_c = strays;
        drop_d      = (|strays) | bus.rx_valid;
        if (|candidates) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = ST_TX;
        end
      end

      ST_TX: begin
        tx_valid_c  = sel_valid;
        req_ready_c = grant_q & {NUM_REQ{bus.tx_ready}};
        drop_d      = bus.rx_valid;
        if (sel_valid && bus.tx_ready && sel_eop) begin
          if (WAIT_RESPONSE != 0) begin
            state_d = ST_RSP;
            timer_d = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end

      ST_RSP: begin
        rx_ready_c  = owner_rsp_ready;
        rsp_valid_c = grant_q & {NUM_REQ{bus.rx_valid}};
        // An accepted eop takes priority over a timeout landing in the same cycle.
        if (bus.rx_valid && owner_rsp_ready) begin
          timer_d = '0;
          if (bus.rx_eop) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = sel_data;
  assign bus.tx_sop    = sel_sop;
  assign bus.tx_eop    = sel_eop;

  assign bus.rx_ready  = rx_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = bus.rx_data;
  assign bus.rsp_sop   = bus.rx_sop;
  assign bus.rsp_eop   = bus.rx_eop;
  assign bus.rsp_error = bus.rx_error;

  assign bus.grant     = grant_q;
  assign bus.timeout   = timeout_q;
  assign bus.drop      = drop_q;

endmodule
